// File: rtl/cond_eval_unit.sv
// cond_eval_unit: NZCV status register, flag-writer scoreboard and
// in-order multi-lane condition evaluation with writeback forwarding.
module cond_eval_unit #(
  parameter int LANES        = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int FWD_EN       = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               flag_wr_en,
  input  logic [3:0]         flag_wr_nzcv,
  input  logic [3:0]         flag_wr_mask,
  input  logic [LANES-1:0]   issue_valid,
  input  logic [4*LANES-1:0] issue_cond,
  input  logic [LANES-1:0]   issue_sets_flags,
  output logic [LANES-1:0]   issue_accept,
  output logic [LANES-1:0]   match_valid,
  output logic [LANES-1:0]   matched,
  output logic [3:0]         status_nzcv,
  output logic [3:0]         pend_cnt
);

  localparam int CW = 8;
  localparam logic FWD = (FWD_EN != 0);
  localparam logic [CW-1:0] MAXC = CW'(MAX_INFLIGHT);

  function automatic logic cond_hit(
    input logic [3:0] f,
    input logic [3:0] c
  );
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    case (c)
      4'h0: r = z;
      4'h1: r = ~z;
      4'h2: r = cy;
      4'h3: r = ~cy;
      4'h4: r = n;
      4'h5: r = ~n;
      4'h6: r = v;
      4'h7: r = ~v;
      4'h8: r = cy & ~z;
      4'h9: r = ~cy | z;
      4'hA: r = (n == v);
      4'hB: r = (n != v);
      4'hC: r = ~z & (n == v);
      4'hD: r = z | (n != v);
      4'hE: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [3:0]       merged;
  logic [3:0]       eff;
  logic             wr_fwd;
  logic             dec;
  logic             fwd_res;
  logic [CW-1:0]    base;
  logic [CW-1:0]    cnt;
  logic [LANES-1:0] acc;
  logic [LANES-1:0] hit;
  logic             chain;
  logic             setter;
  logic [3:0]       c;
  logic             unc;
  logic             res;
  logic             room;
  logic             ok;

  assign merged = (status_nzcv & ~flag_wr_mask)
                | (flag_wr_nzcv & flag_wr_mask);
  assign wr_fwd = FWD & flag_wr_en;
  assign eff    = wr_fwd ? merged : status_nzcv;
  // a write with nothing pending must not underflow the count
  assign dec    = flag_wr_en & (pend_cnt != 4'd0);
  assign base   = CW'(pend_cnt) - CW'(dec);
  assign fwd_res = (pend_cnt == 4'd0)
                 | ((pend_cnt == 4'd1) & wr_fwd);

  // lanes admitted oldest first; cnt tracks the projected count
  always_comb begin
    cnt    = base;
    chain  = ~flush;
    setter = 1'b0;
    acc    = '0;
    hit    = '0;
    c      = '0;
    unc    = 1'b0;
    res    = 1'b0;
    room   = 1'b0;
    ok     = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      c    = issue_cond[4*i +: 4];
      unc  = (c == 4'hE) | (c == 4'hF);
      res  = fwd_res | unc;
      room = ~issue_sets_flags[i]
           | ((cnt + CW'(1)) <= MAXC);
      ok   = chain & issue_valid[i] & res
           & (~setter | unc) & room;
      acc[i] = ok;
      hit[i] = ok & cond_hit(eff, c);
      if (ok & issue_sets_flags[i]) begin
        cnt    = cnt + CW'(1);
        setter = 1'b1;
      end
      chain = ok;
    end
  end

  assign issue_accept = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_nzcv <= 4'd0;
      pend_cnt    <= 4'd0;
      match_valid <= '0;
      matched     <= '0;
    end else begin
      if (flag_wr_en)
        status_nzcv <= merged;
      pend_cnt    <= flush ? 4'd0 : cnt[3:0];
      match_valid <= acc;
      matched     <= hit;
    end
  end

endmodule

// File: tb/tb_cond_eval_unit.sv
// Randomized and directed bench for cond_eval_unit, run on a
// forwarding and a non-forwarding instance against a reference model.
module tb_cond_eval_unit;

  localparam int MX = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       wr = 1'b0;
  logic [3:0] nz = '0;
  logic [3:0] mk = '0;
  logic [1:0] vld = '0;
  logic [1:0] sf = '0;
  logic [7:0] cnd = '0;

  logic [1:0] acc0, mv0, mt0;
  logic [3:0] st0, pc0;
  logic [1:0] acc1, mv1, mt1;
  logic [3:0] st1, pc1;

  int total = 0;
  int bad = 0;

  logic [3:0] m_st[2];
  int         m_pc[2];
  logic [1:0] m_mv[2];
  logic [1:0] m_mt[2];
  logic [1:0] m_acc[2];
  logic [3:0] n_st[2];
  int         n_pc[2];
  logic [1:0] n_mt[2];
  logic [1:0] lacc0, lacc1;

  cond_eval_unit #(.LANES(2), .MAX_INFLIGHT(MX), .FWD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .flag_wr_en(wr), .flag_wr_nzcv(nz), .flag_wr_mask(mk),
    .issue_valid(vld), .issue_cond(cnd), .issue_sets_flags(sf),
    .issue_accept(acc0), .match_valid(mv0), .matched(mt0),
    .status_nzcv(st0), .pend_cnt(pc0)
  );

  cond_eval_unit #(.LANES(2), .MAX_INFLIGHT(MX), .FWD_EN(0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .flag_wr_en(wr), .flag_wr_nzcv(nz), .flag_wr_mask(mk),
    .issue_valid(vld), .issue_cond(cnd), .issue_sets_flags(sf),
    .issue_accept(acc1), .match_valid(mv1), .matched(mt1),
    .status_nzcv(st1), .pend_cnt(pc1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [3:0] f, input logic [3:0] c);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0:  return z;
      1:  return !z;
      2:  return cy;
      3:  return !cy;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return cy && !z;
      9:  return !cy || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_eval(input int k);
    bit fw, setter, stop, unc, ok;
    logic [3:0] e, mrg, c;
    int proj;
    fw = (k == 0);
    mrg = (m_st[k] & ~mk) | (nz & mk);
    e = (fw && wr) ? mrg : m_st[k];
    proj = m_pc[k] - ((wr && m_pc[k] > 0) ? 1 : 0);
    setter = 0;
    stop = flush;
    m_acc[k] = '0;
    n_mt[k] = '0;
    for (int i = 0; i < 2; i++) begin
      c = cnd[4*i +: 4];
      unc = (c >= 14);
      ok = !stop && vld[i]
        && (m_pc[k] == 0 || (m_pc[k] == 1 && wr && fw) || unc)
        && (!setter || unc)
        && (!sf[i] || proj + 1 <= MX);
      if (!ok) stop = 1;
      else begin
        m_acc[k][i] = 1'b1;
        n_mt[k][i] = hit(e, c);
        if (sf[i]) begin
          proj++;
          setter = 1;
        end
      end
    end
    n_st[k] = wr ? mrg : m_st[k];
    n_pc[k] = flush ? 0 : proj;
  endtask

  task automatic model_reset;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = '0; m_pc[k] = 0; m_mv[k] = '0; m_mt[k] = '0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_st"}, st0, 0);
    chk({tag, "_pc"}, pc0, 0);
    chk({tag, "_mv"}, mv0, 0);
    chk({tag, "_mt"}, mt0, 0);
    chk({tag, "_st_nf"}, st1, 0);
    chk({tag, "_pc_nf"}, pc1, 0);
    chk({tag, "_mv_nf"}, mv1, 0);
    chk({tag, "_mt_nf"}, mt1, 0);
  endtask

  // one cycle: inputs already driven just after a falling edge
  task automatic step;
    #1;
    for (int k = 0; k < 2; k++) model_eval(k);
    lacc0 = acc0;
    lacc1 = acc1;
    chk("accept", acc0, m_acc[0]);
    chk("accept_nf", acc1, m_acc[1]);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_st[k] = n_st[k];
      m_pc[k] = n_pc[k];
      m_mv[k] = m_acc[k];
      m_mt[k] = n_mt[k];
    end
    #1;
    chk("match_valid", mv0, m_mv[0]);
    chk("matched", mt0, m_mt[0]);
    chk("status", st0, m_st[0]);
    chk("pend", pc0, m_pc[0]);
    chk("match_valid_nf", mv1, m_mv[1]);
    chk("matched_nf", mt1, m_mt[1]);
    chk("status_nf", st1, m_st[1]);
    chk("pend_nf", pc1, m_pc[1]);
    @(negedge clk);
  endtask

  task automatic drive(
    input logic [1:0] v, input logic [3:0] c0, input logic [3:0] c1,
    input logic [1:0] s, input logic w, input logic [3:0] n,
    input logic [3:0] m, input logic f
  );
    vld = v; cnd = {c1, c0}; sf = s;
    wr = w; nz = n; mk = m; flush = f;
  endtask

  task automatic idle;
    drive(2'b00, 4'h0, 4'h0, 2'b00, 1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  initial begin
    model_reset();
    idle();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // EQ on cleared flags, then after Z is written
    drive(2'b01, 4'h0, 4'h0, 2'b00, 1'b0, 4'h0, 4'h0, 1'b0);
    step();
    chk("t1_mv", mv0, 1);
    chk("t1_mt", mt0, 0);
    drive(2'b00, 4'h0, 4'h0, 2'b00, 1'b1, 4'h4, 4'hF, 1'b0);
    step();
    chk("t1_st", st0, 4'h4);
    drive(2'b01, 4'h0, 4'h0, 2'b00, 1'b0, 4'h0, 4'h0, 1'b0);
    step();
    chk("t1_eq", mt0, 1);

    // full decode sweep on lane 0
    for (int f = 0; f < 16; f++) begin
      drive(2'b00, 4'h0, 4'h0, 2'b00, 1'b1, 4'(f), 4'hF, 1'b0);
      step();
      for (int c = 0; c < 16; c++) begin
        drive(2'b01, 4'(c), 4'h0, 2'b00, 1'b0, 4'h0, 4'h0, 1'b0);
        step();
        if (f == 0 && c == 9) chk("pin_ls", mt0, 1);
        if (f == 9 && c == 10) chk("pin_ge", mt0, 1);
        if (f == 8 && c == 12) chk("pin_gt", mt0, 0);
        if (f == 15 && c == 15) chk("pin_nv", mt0, 0);
      end
    end

    // setter in lane 0 stalls the younger EQ; forwarding resolves it
    drive(2'b11, 4'hE, 4'h0, 2'b01, 1'b0, 4'h0, 4'h0, 1'b0);
    step();
    chk("s3_acc", lacc0, 2'b01);
    chk("s3_pc", pc0, 1);
    drive(2'b01, 4'h0, 4'h0, 2'b00, 1'b1, 4'h4, 4'hF, 1'b0);
    step();
    chk("s3_fwd_acc", lacc0, 2'b01);
    chk("s3_fwd_mt", mt0, 2'b01);
    chk("s4_nf_acc", lacc1, 2'b00);
    drive(2'b01, 4'h0, 4'h0, 2'b00, 1'b0, 4'h0, 4'h0, 1'b0);
    step();
    chk("s4_nf_acc2", lacc1, 2'b01);
    chk("s4_nf_mt", mt1, 2'b01);

    // fill the scoreboard, then flush with a write
    drive(2'b11, 4'hE, 4'hE, 2'b11, 1'b0, 4'h0, 4'h0, 1'b0);
    step();
    step();
    chk("s5_pc4", pc0, 4);
    drive(2'b11, 4'hE, 4'hE, 2'b10, 1'b0, 4'h0, 4'h0, 1'b0);
    step();
    chk("s5_acc", lacc0, 2'b01);
    chk("s5_pc_hold", pc0, 4);
    drive(2'b11, 4'hE, 4'hE, 2'b00, 1'b1, 4'hA, 4'hF, 1'b1);
    step();
    chk("s5_flush_acc", lacc0, 0);
    chk("s5_flush_pc", pc0, 0);
    chk("s5_flush_st", st0, 4'hA);

    // asynchronous reset in the middle of a cycle
    drive(2'b11, 4'hE, 4'hE, 2'b11, 1'b0, 4'h0, 4'h0, 1'b0);
    step();
    drive(2'b01, 4'hE, 4'hE, 2'b01, 1'b0, 4'h0, 4'h0, 1'b0);
    step();
    chk("s6_pc3", pc0, 3);
    drive(2'b11, 4'hE, 4'hE, 2'b11, 1'b1, 4'h5, 4'hF, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b1;

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      vld   = 2'($urandom);
      cnd   = 8'($urandom);
      sf    = 2'($urandom) & 2'($urandom);
      wr    = ($urandom_range(0, 2) == 0);
      nz    = 4'($urandom);
      mk    = 4'($urandom);
      flush = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
